// File: rtl/layer_buf_pkg.sv
// Shared sizing and FSM encoding for the layer5 buffer controller.
package layer_buf_pkg;

    localparam int L5_DEPTH = 112;
    localparam int L5_AW    = 7;
    localparam int L5_DW    = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } buf_state_e;

endpackage

// File: rtl/layer5_buffer_ctrl.sv
// Layer5 buffer controller: fills a dual-port SRAM once through port A and
// serves in-order-independent reads of already-written words through port B.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | pointer held at 0; leaves for FILL on the first cycle without clear
// FILL    | accepting producer words at wr_ptr; last address moves to FULL
// FULL    | all DEPTH words stored; reads only, until clear
module layer5_buffer_ctrl
    import layer_buf_pkg::*;
#(
    parameter int DEPTH = L5_DEPTH,
    parameter int AW    = L5_AW,
    parameter int DW    = L5_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] wr_count,
    output logic          layer_full,
    output logic          layer_done,
    output logic          sram_oea,
    output logic          sram_wean,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_dia,
    output logic          sram_oeb,
    output logic          sram_webn,
    output logic [AW-1:0] sram_b,
    output logic [DW-1:0] sram_dib,
    input  logic [DW-1:0] sram_dob
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] DEPTH_W   = AW'(DEPTH);

    buf_state_e    state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic          layer_full_q;
    logic          layer_done_q;
    logic          rd_valid_q;
    logic [DW-1:0] rd_hold_q;
    logic          wr_acc;
    logic          last_wr;

    assign wr_ready = (state_q == ST_FILL) && !clear;
    assign wr_acc   = wr_valid && wr_ready;
    assign last_wr  = wr_acc && (wr_ptr_q == LAST_ADDR);

    // The pointer parks on the last address; FULL reports the saturated count.
    assign wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? wr_ptr_q : wr_ptr_q + AW'(1);
    assign wr_count = (state_q == ST_FULL) ? DEPTH_W : wr_ptr_q;

    // Only written addresses are granted, so port B never collides with port A.
    assign rd_gnt = rd_req && (rd_addr < wr_count) && (rd_addr < DEPTH_W) && !clear;

    assign sram_oea  = 1'b0;
    assign sram_wean = !wr_acc;
    assign sram_a    = wr_ptr_q;
    assign sram_dia  = wr_data;

    assign sram_oeb  = rd_gnt;
    assign sram_webn = 1'b1;
    assign sram_b    = rd_addr;
    assign sram_dib  = '0;

    assign layer_full = layer_full_q;
    assign layer_done = layer_done_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_valid_q ? sram_dob : rd_hold_q;

    // Fill sequencer: state, write pointer and the full/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            layer_full_q <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= last_wr;
            case (state_q)
                ST_IDLE: begin
                    wr_ptr_q <= '0;
                    if (!clear) begin
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (clear) begin
                        state_q  <= ST_IDLE;
                        wr_ptr_q <= '0;
                    end else if (wr_acc) begin
                        wr_ptr_q <= wr_ptr_d;
                        if (last_wr) begin
                            state_q      <= ST_FULL;
                            layer_full_q <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (clear) begin
                        state_q      <= ST_IDLE;
                        wr_ptr_q     <= '0;
                        layer_full_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    wr_ptr_q     <= '0;
                    layer_full_q <= 1'b0;
                end
            endcase
        end
    end

    // Read return: valid one cycle after grant; the last word is held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            rd_valid_q <= rd_gnt;
            if (rd_valid_q) begin
                rd_hold_q <= sram_dob;
            end
        end
    end

endmodule

// File: tb/tb_layer5_buffer_ctrl.sv
// Randomized self-checking bench for layer5_buffer_ctrl with a behavioural
// SRAM and a word-count based reference model.
module tb_layer5_buffer_ctrl;

    localparam int DEPTH = 112;
    localparam int AW    = 7;
    localparam int DW    = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] wr_count;
    logic          layer_full;
    logic          layer_done;
    logic          sram_oea;
    logic          sram_wean;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_dia;
    logic          sram_oeb;
    logic          sram_webn;
    logic [AW-1:0] sram_b;
    logic [DW-1:0] sram_dib;
    logic [DW-1:0] sram_dob;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: number of words stored, whether filling has been armed
    int            count;
    bit            started;
    logic [DW-1:0] mem_ref [DEPTH];
    bit            exp_valid;
    bit            exp_done;
    logic [DW-1:0] exp_data;
    int            done_seen;

    logic [DW-1:0] sram_mem [128];

    layer5_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .wr_count   (wr_count),
        .layer_full (layer_full),
        .layer_done (layer_done),
        .sram_oea   (sram_oea),
        .sram_wean  (sram_wean),
        .sram_a     (sram_a),
        .sram_dia   (sram_dia),
        .sram_oeb   (sram_oeb),
        .sram_webn  (sram_webn),
        .sram_b     (sram_b),
        .sram_dib   (sram_dib),
        .sram_dob   (sram_dob)
    );

    always #5 clk = ~clk;

    // Synchronous dual-port SRAM: port A writes, port B reads with one cycle latency.
    always @(posedge clk) begin
        if (!sram_wean) sram_mem[sram_a] <= sram_dia;
        if (sram_oeb)   sram_dob <= sram_mem[sram_b];
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 127));
        return AW'($urandom_range(0, (count < DEPTH) ? count : DEPTH - 1));
    endfunction

    // One clock cycle: drive at negedge, compare outputs, advance the model.
    task automatic step(input bit c, input bit wv, input logic [DW-1:0] wd,
                        input bit rq, input logic [AW-1:0] ra);
        bit exp_ready;
        bit exp_gnt;
        bit acc;
        @(negedge clk);
        clear = c; wr_valid = wv; wr_data = wd; rd_req = rq; rd_addr = ra;
        #1;
        exp_ready = started && (count < DEPTH) && !c;
        exp_gnt   = rq && (int'(ra) < count) && (int'(ra) < DEPTH) && !c;
        check("wr_ready",   DW'(wr_ready),   DW'(exp_ready));
        check("rd_gnt",     DW'(rd_gnt),     DW'(exp_gnt));
        check("sram_oeb",   DW'(sram_oeb),   DW'(exp_gnt));
        check("sram_wean",  DW'(sram_wean),  DW'(!(wv && exp_ready)));
        check("sram_webn",  DW'(sram_webn),  DW'(1));
        check("sram_oea",   DW'(sram_oea),   DW'(0));
        check("sram_dib",   sram_dib,        '0);
        if (exp_ready) check("sram_a", DW'(sram_a), DW'(count));
        if (rq) check("sram_b", DW'(sram_b), DW'(ra));
        check("wr_count",   DW'(wr_count),   DW'(count));
        check("layer_full", DW'(layer_full), DW'(count == DEPTH));
        check("layer_done", DW'(layer_done), DW'(exp_done));
        check("rd_valid",   DW'(rd_valid),   DW'(exp_valid));
        check("rd_data",    rd_data,         exp_data);
        if (layer_done) done_seen++;

        acc       = wv && exp_ready;
        exp_done  = acc && (count == DEPTH - 1);
        exp_valid = exp_gnt;
        if (exp_gnt) exp_data = mem_ref[ra];
        if (acc) begin
            mem_ref[count] = wd;
            count++;
        end
        if (c) begin
            started = 1'b0;
            count   = 0;
        end else begin
            started = 1'b1;
        end
    endtask

    // Asynchronous reset between clock edges; outputs are compared before any edge.
    task automatic async_reset();
        @(negedge clk);
        clear = 1'b0; wr_valid = 1'b1; rd_req = 1'b1; rd_addr = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_wr_ready",   DW'(wr_ready),   '0);
        check("rst_rd_gnt",     DW'(rd_gnt),     '0);
        check("rst_rd_valid",   DW'(rd_valid),   '0);
        check("rst_rd_data",    rd_data,         '0);
        check("rst_layer_full", DW'(layer_full), '0);
        check("rst_layer_done", DW'(layer_done), '0);
        check("rst_sram_wean",  DW'(sram_wean),  DW'(1));
        check("rst_sram_oeb",   DW'(sram_oeb),   '0);
        check("rst_wr_count",   DW'(wr_count),   '0);
        count = 0; started = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_data = '0;
        repeat (2) @(negedge clk);
        wr_valid = 1'b0; rd_req = 1'b0;
        rst_n = 1'b1;
        started = 1'b1;
    endtask

    initial begin
        int done_before;

        count = 0; started = 1'b0; exp_valid = 1'b0; exp_done = 1'b0; exp_data = '0;
        done_seen = 0;
        async_reset();

        // word 5 is held off until it is written, then returned
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, rand_word(), 1'b1, AW'(5));
        step(1'b0, 1'b1, rand_word(), 1'b1, AW'(5));
        step(1'b0, 1'b0, '0, 1'b1, AW'(5));
        step(1'b0, 1'b0, '0, 1'b0, '0);

        // simultaneous write at address 10 and read of address 3
        for (int i = 0; i < 40 && count < 10; i++) step(1'b0, 1'b1, rand_word(), 1'b0, '0);
        step(1'b0, 1'b1, rand_word(), 1'b1, AW'(3));

        // random fill with random reads, including unwritten and out-of-range addresses
        for (int i = 0; i < 3000 && count < DEPTH; i++)
            step(1'b0, $urandom_range(0, 3) != 0, rand_word(), 1'(($urandom_range(0, 1))), rand_addr());
        check("fill_done_pulses", DW'(done_seen + (exp_done ? 1 : 0)), DW'(1));

        // back-to-back reads in FULL; out-of-range addresses never granted
        for (int i = 0; i < 60; i++) step(1'b0, 1'(($urandom_range(0, 1))), rand_word(), 1'b1, rand_addr());
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, AW'(112));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1, AW'(127));

        // clear in FULL, then refill from address 0
        step(1'b1, 1'b1, rand_word(), 1'b1, AW'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rand_word(), 1'b1, AW'(0));

        // random traffic with occasional clear
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, rand_word(),
                 1'(($urandom_range(0, 1))), rand_addr());

        // reset part way through a fill
        step(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 200 && count < 50; i++) step(1'b0, 1'b1, rand_word(), 1'b1, rand_addr());
        async_reset();

        // continuous stream of DEPTH words from address 0; done pulses once
        done_before = done_seen;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, rand_word(), 1'(($urandom_range(0, 1))), rand_addr());
        step(1'b0, 1'b0, '0, 1'b1, rand_addr());
        step(1'b0, 1'b0, '0, 1'b0, '0);
        check("stream_done_pulses", DW'(done_seen - done_before), DW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
